// File: rtl/smod_pkg.sv
// Shared types and constants for the iterative signed divider.
package smod_pkg;

    localparam int DATAWIDTH_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Counter must hold 0..w, so it needs clog2(w+1) bits.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/smod_step.sv
// One restoring-division step: shift the dividend bit in, trial subtract, keep or restore.
module smod_step #(
    parameter int W = 64
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic         qbit_o
);
    logic [W:0] shifted;
    logic [W:0] trial;

    // One extra bit so a shifted remainder up to 2*|c|-1 never overflows.
    assign shifted = {rem_i, bit_i};
    assign trial   = shifted - {1'b0, div_i};
    assign qbit_o  = ~trial[W];
    assign rem_o   = qbit_o ? trial[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/smod_iter.sv
// Iterative signed divider: magnitudes divided MSB-first, one bit per cycle, signs fixed up after.
module smod_iter
    import smod_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] c,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic signed [DATAWIDTH-1:0] q,
    output logic signed [DATAWIDTH-1:0] r,
    output logic                        div_zero
);
    localparam int CW = cnt_width(DATAWIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

    state_e                 state_q, state_d;
    logic [DATAWIDTH-1:0]   quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
    logic [DATAWIDTH-1:0]   dvs_q, dvs_d;
    logic [DATAWIDTH-1:0]   rem_q, rem_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   negq_q, negq_d;
    logic                   negr_q, negr_d;
    logic [DATAWIDTH-1:0]   q_q, q_d;
    logic [DATAWIDTH-1:0]   r_q, r_d;
    logic                   dz_q, dz_d;

    logic [DATAWIDTH-1:0]   a_u, c_u;
    logic [DATAWIDTH-1:0]   step_rem;
    logic                   step_qbit;

    assign a_u = a;
    assign c_u = c;

    smod_step #(.W(DATAWIDTH)) u_step (
        .rem_i  (rem_q),
        .bit_i  (quo_q[DATAWIDTH-1]),
        .div_i  (dvs_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d = '0;
                    rem_d = '0;
                    if (c_u == '0) begin
                        // Preload the fixed c==0 answer so FIX passes it straight through.
                        state_d = FIX;
                        quo_d   = '1;
                        rem_d   = a_u;
                        dvs_d   = '0;
                        negq_d  = 1'b0;
                        negr_d  = 1'b0;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = ITER;
                        quo_d   = a_u[DATAWIDTH-1] ? -a_u : a_u;
                        dvs_d   = c_u[DATAWIDTH-1] ? -c_u : c_u;
                        negr_d  = a_u[DATAWIDTH-1];
                        negq_d  = a_u[DATAWIDTH-1] ^ c_u[DATAWIDTH-1];
                        dz_d    = 1'b0;
                    end
                end
            end
            ITER: begin
                quo_d = {quo_q[DATAWIDTH-2:0], step_qbit};
                rem_d = step_rem;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX: begin
                q_d     = negq_q ? -quo_q : quo_q;
                r_d     = negr_q ? -rem_q : rem_q;
                state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            quo_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign q         = q_q;
    assign r         = r_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_smod_iter.sv
// Randomized self-checking bench for smod_iter against a plain signed-arithmetic model.
module tb_smod_iter;
    localparam int W = 64;
    localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic rsp_ready = 1'b1;
    logic signed [W-1:0] a = '0;
    logic signed [W-1:0] c = '0;
    logic req_ready, rsp_valid, div_zero;
    logic signed [W-1:0] q, r;

    int errors = 0;
    int checks = 0;

    smod_iter #(.DATAWIDTH(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .a(a), .c(c), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .q(q), .r(r), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // Reference: language-level signed / and %, with the two defined special cases.
    // Latency counts the handshake edge as edge 1.
    function automatic void model(input logic signed [W-1:0] ma, input logic signed [W-1:0] mc,
                                  output logic signed [W-1:0] mq, output logic signed [W-1:0] mr,
                                  output logic mdz, output int mlat);
        if (mc == 0) begin
            mq = -1; mr = ma; mdz = 1'b1; mlat = 2;
        end else if (ma == MINV && mc == -1) begin
            mq = MINV; mr = 0; mdz = 1'b0; mlat = W + 2;
        end else begin
            mq = ma / mc; mr = ma % mc; mdz = 1'b0; mlat = W + 2;
        end
    endfunction

    // Drives one request and waits (bounded) for its response; consumes it if rsp_ready=1.
    task automatic run_op(input logic signed [W-1:0] ta, input logic signed [W-1:0] tc,
                          output logic signed [W-1:0] oq, output logic signed [W-1:0] orr,
                          output logic odz, output int lat, output bit rdy);
        bit got;
        @(negedge clk);
        rdy = req_ready;
        a = ta; c = tc; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        a = {$urandom, $urandom};
        c = {$urandom, $urandom};
        lat = 1; got = 1'b0;
        while (!got && lat < W + 20) begin
            if (rsp_valid === 1'b1) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        oq = q; orr = r; odz = div_zero;
        if (got && rsp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_op(input string name, input logic signed [W-1:0] ta, input logic signed [W-1:0] tc);
        logic signed [W-1:0] gq, gr, eq, er;
        logic gdz, edz;
        int glat, elat;
        bit rdy;
        run_op(ta, tc, gq, gr, gdz, glat, rdy);
        model(ta, tc, eq, er, edz, elat);
        checks++;
        if (gq !== eq || gr !== er || gdz !== edz || glat !== elat || rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s a=%0d c=%0d got q=%0d r=%0d dz=%0b lat=%0d rdy=%0b exp q=%0d r=%0d dz=%0b lat=%0d rdy=1",
                     name, ta, tc, gq, gr, gdz, glat, rdy, eq, er, edz, elat);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #10;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || q !== 0 || r !== 0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rdy=%0b vld=%0b q=%0d r=%0d dz=%0b exp 1 0 0 0 0",
                     req_ready, rsp_valid, q, r, div_zero);
        end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_basic();
        check_op("basic_17_5", 64'sd17, 64'sd5);
        check_op("basic_zero_dividend", 64'sd0, 64'sd3);
        check_op("basic_small_big", 64'sd4, 64'sd9);
    endtask

    task automatic test_signs();
        check_op("sign_neg_pos", -64'sd17, 64'sd5);
        check_op("sign_pos_neg", 64'sd17, -64'sd5);
        check_op("sign_neg_neg", -64'sd17, -64'sd5);
    endtask

    task automatic test_edges();
        check_op("div_zero_9", 64'sd9, 64'sd0);
        check_op("div_zero_min", MINV, 64'sd0);
        check_op("min_by_neg1", MINV, -64'sd1);
        check_op("max_by_1", MAXV, 64'sd1);
        check_op("min_by_min", MINV, MINV);
    endtask

    task automatic test_backpressure();
        logic signed [W-1:0] gq, gr, eq, er;
        logic gdz, edz;
        int glat, elat;
        bit rdy;
        rsp_ready = 1'b0;
        run_op(64'sd1000, -64'sd33, gq, gr, gdz, glat, rdy);
        model(64'sd1000, -64'sd33, eq, er, edz, elat);
        checks++;
        if (gq !== eq || gr !== er || gdz !== edz || glat !== elat) begin
            errors++;
            $display("FAIL bp_result got q=%0d r=%0d dz=%0b lat=%0d exp q=%0d r=%0d dz=%0b lat=%0d",
                     gq, gr, gdz, glat, eq, er, edz, elat);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || q !== eq || r !== er || div_zero !== edz) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got vld=%0b rdy=%0b q=%0d r=%0d exp vld=1 rdy=0 q=%0d r=%0d",
                         i, rsp_valid, req_ready, q, r, eq, er);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got vld=%0b rdy=%0b exp vld=0 rdy=1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [W-1:0] gq, gr;
        logic gdz;
        int glat;
        bit rdy;
        for (int i = 0; i < 3; i++) begin
            run_op(64'sd50 + i, 64'sd7, gq, gr, gdz, glat, rdy);
            // run_op returns just after the response-handshake edge.
            checks++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || gq !== (64'sd50 + i) / 7) begin
                errors++;
                $display("FAIL b2b_ready i=%0d got rdy=%0b vld=%0b q=%0d exp rdy=1 vld=0 q=%0d",
                         i, req_ready, rsp_valid, gq, (64'sd50 + i) / 7);
            end
        end
    endtask

    task automatic test_reset_abort();
        bit seen;
        @(negedge clk);
        a = 64'sd100; c = 64'sd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || q !== 0 || r !== 0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got rdy=%0b vld=%0b q=%0d r=%0d dz=%0b exp 1 0 0 0 0",
                     req_ready, rsp_valid, q, r, div_zero);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_rsp got rsp_valid=1 exp rsp_valid=0");
        end
        check_op("abort_rerun_100_7", 64'sd100, 64'sd7);
    endtask

    function automatic logic signed [W-1:0] pick(input bit divisor);
        logic signed [W-1:0] v;
        case ($urandom_range(0, 5))
            0: case ($urandom_range(0, 5))
                   0: v = MINV; 1: v = MAXV; 2: v = -1; 3: v = 1; 4: v = 0; default: v = MINV + 1;
               endcase
            1, 2: v = $urandom_range(0, 1000);
            3: v = {32'd0, $urandom};
            default: v = {$urandom, $urandom};
        endcase
        if (divisor && $urandom_range(0, 1) == 0) v = -v;
        return v;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 600; i++) check_op("random", pick(1'b0), pick(1'b1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_edges();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
